// File: rtl/intf_array_rr_arb_pkg.sv
// Shared types and helpers for the interface-array round-robin arbiter.
// Imported by the picker and the top level.
package intf_arb_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic [DEFAULT_DATA_W-1:0] payload_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Index width for n ports; never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/intf_array_rr_arb_if.sv
// Single requester channel: valid/data from the initiator, ready from the arbiter.
interface req_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport initiator (output valid, output data, input ready);
  modport target    (input valid, input data, output ready);
endinterface

// File: rtl/intf_array_rr_arb_rr_pick.sv
// Combinational round-robin search: first valid port at or after ptr, wrapping.
module rr_pick
  import intf_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any_valid,
  output logic [IDX_W-1:0]     g
);

  // Scan NUM_PORTS positions starting at ptr; the first hit wins.
  always_comb begin
    any_valid = 1'b0;
    g         = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end else begin
        idx = idx;
      end
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        g         = IDX_W'(idx);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/intf_array_rr_arb.sv
// Merges an array of req_if channels into one registered output stream,
// tagging each beat with its source index and counting grants per port.
module intf_array_rr_arb
  import intf_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  req_if.target                         reqs [0:NUM_PORTS-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [idx_w(NUM_PORTS)-1:0]   out_src,
  output logic [NUM_PORTS*CNT_W-1:0]    grant_cnt
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] valid_s;
  logic [NUM_PORTS-1:0] ready_s;
  logic [DATA_W-1:0]    data_s [NUM_PORTS];
  logic                 any_valid_s;
  logic [IDX_W-1:0]     g_s;
  logic                 can_accept_s;
  logic                 hs_s;

  arb_state_e           state_r;
  arb_state_e           state_s;
  logic [IDX_W-1:0]     ptr_r;
  logic [DATA_W-1:0]    out_data_r;
  logic [IDX_W-1:0]     out_src_r;
  logic [CNT_W-1:0]     cnt_r [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign valid_s[i]    = reqs[i].valid;
    assign data_s[i]     = reqs[i].data;
    assign reqs[i].ready = ready_s[i];
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .valid     (valid_s),
    .ptr       (ptr_r),
    .any_valid (any_valid_s),
    .g         (g_s)
  );

  // Handshake is gated by rst_n so no ready escapes while reset is held.
  assign can_accept_s = (state_r == EMPTY) || out_ready;
  assign hs_s         = rst_n && can_accept_s && any_valid_s;

  // State register for the one-entry output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: fill on handshake, drain when downstream takes the beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (hs_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (hs_s) begin
          state_s = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // Outputs: one-hot ready to the granted port, out_valid from the state.
  always_comb begin
    ready_s   = {NUM_PORTS{1'b0}};
    out_valid = (state_r == FULL);
    if (hs_s) begin
      ready_s[g_s] = 1'b1;
    end else begin
      ready_s = {NUM_PORTS{1'b0}};
    end
  end

  // Payload, source tag, pointer and saturating grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= {DATA_W{1'b0}};
      out_src_r  <= {IDX_W{1'b0}};
      ptr_r      <= {IDX_W{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else if (hs_s) begin
      out_data_r <= data_s[g_s];
      out_src_r  <= g_s;
      ptr_r      <= (g_s == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}} : g_s + IDX_W'(1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((g_s == IDX_W'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end else begin
      out_data_r <= out_data_r;
      out_src_r  <= out_src_r;
      ptr_r      <= ptr_r;
    end
  end

  assign out_data = out_data_r;
  assign out_src  = out_src_r;

endmodule
